// File: rtl/pulse_sync_pkg.sv
// pulse_sync_pkg: shared state encoding and default sizing for the pulse synchroniser feeder
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CHECK   = 2'd2,
        BACKOFF = 2'd3
    } state_e;

    localparam int DEF_CNT_W       = 4;
    localparam int DEF_BACKOFF_CYC = 8;
    localparam int DEF_BO_W        = 8;

endpackage

// File: rtl/sat_updown_cnt.sv
// sat_updown_cnt: saturating up/down counter that flags increments dropped at full scale
//   clk, rst      : clock, synchronous active-high reset
//   inc, dec      : count up / down requests; both together cancel
//   cnt           : current count
//   sat_drop      : high in the cycle an increment is dropped because cnt is at max
module sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat_drop
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         full;

    assign full     = &cnt_q;
    assign sat_drop = inc && !dec && full;
    assign cnt      = cnt_q;

    // Decrement is guarded at zero so a stray request can never wrap the count.
    always_comb begin
        cnt_d = (inc && !dec && !full)          ? cnt_q + W'(1) :
                (dec && !inc && cnt_q != '0)    ? cnt_q - W'(1) :
                                                  cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pulse_sync_feeder.sv
// pulse_sync_feeder: banks event pulses as credits and replays them into a handshake synchroniser with retry
//   clk, rst   : source-domain clock, synchronous active-high reset
//   in_pulse   : event pulse, one credit per high cycle
//   sync_fail  : synchroniser reject, arrives in the cycle after out_pulse
//   ovf_clr    : clears the sticky overflow flag
//   out_pulse  : single-cycle pulse to the synchroniser
//   pending    : outstanding credit count
//   busy       : attempt in progress or credits outstanding
//   overflow   : sticky, an event was dropped at saturation
module pulse_sync_feeder
    import pulse_sync_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BACKOFF_CYC = DEF_BACKOFF_CYC,
    parameter int BO_W        = DEF_BO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_pulse,
    input  logic             sync_fail,
    input  logic             ovf_clr,
    output logic             out_pulse,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF_CYC - 1);

    state_e          state_q, state_d;
    logic [BO_W-1:0] bo_q, bo_d;
    logic            ovf_q, ovf_d;
    logic            dec;
    logic            sat_drop;

    // A credit is consumed only when the attempt is confirmed accepted.
    assign dec = (state_q == CHECK) && !sync_fail;

    sat_updown_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (in_pulse),
        .dec      (dec),
        .cnt      (pending),
        .sat_drop (sat_drop)
    );

    always_comb begin
        state_d = state_q;
        bo_d    = bo_q;
        case (state_q)
            IDLE:    state_d = (pending != '0) ? ISSUE : IDLE;
            ISSUE:   state_d = CHECK;
            CHECK: begin
                state_d = sync_fail ? BACKOFF : IDLE;
                bo_d    = sync_fail ? BO_LOAD : bo_q;
            end
            BACKOFF: begin
                state_d = (bo_q == '0) ? IDLE : BACKOFF;
                bo_d    = (bo_q == '0) ? bo_q : bo_q - BO_W'(1);
            end
            default: state_d = IDLE;
        endcase
        // A drop in the same cycle as a clear must still be recorded.
        ovf_d = sat_drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bo_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_pulse = (state_q == ISSUE);
    assign busy      = (state_q != IDLE) || (pending != '0);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_sync_feeder.sv
// tb_pulse_sync_feeder: directed self-checking bench for pulse_sync_feeder
module tb_pulse_sync_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_pulse = 1'b0;
    logic       sync_fail = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       out_pulse;
    logic [3:0] pending;
    logic       busy;
    logic       overflow;

    int nvec = 0;
    int nerr = 0;

    // responder: 0 = accept unless rej_left, 1 = reject all, 2 = synchroniser model
    int mode = 0;
    int rej_left = 0;
    int sync_hold = 0;
    int accepted = 0;
    int rejected = 0;
    logic prev_out = 1'b0;

    pulse_sync_feeder #(.CNT_W(4), .BACKOFF_CYC(8), .BO_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pulse  (in_pulse),
        .sync_fail (sync_fail),
        .ovf_clr   (ovf_clr),
        .out_pulse (out_pulse),
        .pending   (pending),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // One clock; sync_fail is produced as a registered reply to the previous cycle's out_pulse.
    task automatic step();
        logic f;
        prev_out = out_pulse;
        @(posedge clk);
        #1;
        f = 1'b0;
        if (sync_hold > 0) sync_hold--;
        if (prev_out && !rst) begin
            if (mode == 1) f = 1'b1;
            else if (mode == 2) begin
                f = (sync_hold > 0);
                if (!f) sync_hold = 6;
            end else if (rej_left > 0) begin
                f = 1'b1;
                rej_left--;
            end
            if (f) rejected++;
            else accepted++;
        end
        sync_fail = f;
    endtask

    task automatic wait_out(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_pulse && n < bound);
        if (!out_pulse) n = bound + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_pulse = 1'b0; ovf_clr = 1'b0; mode = 0; rej_left = 0; sync_hold = 0;
        step(); step();
        rst = 1'b0;
        accepted = 0; rejected = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        nvec++; if (out_pulse !== 1'b0) begin $display("FAIL reset_out_pulse got %b want 0", out_pulse); nerr++; end
        nvec++; if (pending !== 4'd0) begin $display("FAIL reset_pending got %0d want 0", pending); nerr++; end
        nvec++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); nerr++; end
        nvec++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %b want 0", overflow); nerr++; end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] exp_p [5] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
        logic       exp_o [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        in_pulse = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            in_pulse = 1'b0;
            nvec++; if (pending !== exp_p[i]) begin $display("FAIL single_pending[%0d] got %0d want %0d", i, pending, exp_p[i]); nerr++; end
            nvec++; if (out_pulse !== exp_o[i]) begin $display("FAIL single_out[%0d] got %b want %b", i, out_pulse, exp_o[i]); nerr++; end
            nvec++; if (busy !== exp_b[i]) begin $display("FAIL single_busy[%0d] got %b want %b", i, busy, exp_b[i]); nerr++; end
        end
    endtask

    task automatic test_forced_reject();
        int n;
        do_reset();
        rej_left = 1;
        in_pulse = 1'b1;
        step();
        in_pulse = 1'b0;
        wait_out(10, n);
        nvec++; if (n !== 1) begin $display("FAIL reject_first_latency got %0d want 1", n); nerr++; end
        wait_out(20, n);
        nvec++; if (n !== 11) begin $display("FAIL reject_retry_gap got %0d want 11", n); nerr++; end
        nvec++; if (pending !== 4'd1) begin $display("FAIL reject_pending_held got %0d want 1", pending); nerr++; end
        step(); step();
        nvec++; if (pending !== 4'd0) begin $display("FAIL reject_drain got %0d want 0", pending); nerr++; end
        nvec++; if (accepted !== 1 || rejected !== 1) begin $display("FAIL reject_counts got acc=%0d rej=%0d want 1/1", accepted, rejected); nerr++; end
    endtask

    task automatic test_back_to_back();
        int last = -1, cyc = 0, last_rej = 0, bad_gap = 0;
        do_reset();
        mode = 2;
        for (int i = 0; i < 3; i++) begin
            in_pulse = 1'b1;
            step(); cyc++;
        end
        in_pulse = 1'b0;
        while ((busy || sync_fail) && cyc < 300) begin
            if (out_pulse) begin
                if (last >= 0 && last_rej != rejected - (sync_fail ? 1 : 0) && cyc - last != 11) bad_gap++;
                last_rej = rejected;
                last = cyc;
            end
            step(); cyc++;
            if (out_pulse && rejected > last_rej && cyc - last != 11) bad_gap++;
            if (out_pulse && rejected > last_rej) last_rej = rejected;
            if (out_pulse) last = cyc;
        end
        nvec++; if (cyc >= 300) begin $display("FAIL burst_timeout got %0d cycles want <300", cyc); nerr++; end
        nvec++; if (accepted !== 3) begin $display("FAIL burst_delivered got %0d want 3", accepted); nerr++; end
        nvec++; if (rejected < 1) begin $display("FAIL burst_rejects got %0d want >=1", rejected); nerr++; end
        nvec++; if (bad_gap !== 0) begin $display("FAIL burst_backoff_gap got %0d bad gaps want 0", bad_gap); nerr++; end
        nvec++; if (pending !== 4'd0) begin $display("FAIL burst_pending got %0d want 0", pending); nerr++; end
    endtask

    task automatic test_saturation();
        do_reset();
        mode = 1;
        for (int i = 1; i <= 17; i++) begin
            in_pulse = 1'b1;
            step();
            if (i == 15) begin
                nvec++; if (pending !== 4'd15) begin $display("FAIL sat_pending15 got %0d want 15", pending); nerr++; end
                nvec++; if (overflow !== 1'b0) begin $display("FAIL sat_no_ovf15 got %b want 0", overflow); nerr++; end
            end
            if (i == 16) begin
                nvec++; if (overflow !== 1'b1) begin $display("FAIL sat_ovf16 got %b want 1", overflow); nerr++; end
            end
        end
        in_pulse = 1'b0;
        nvec++; if (pending !== 4'd15) begin $display("FAIL sat_pending_hold got %0d want 15", pending); nerr++; end
        in_pulse = 1'b1; ovf_clr = 1'b1;
        step();
        nvec++; if (overflow !== 1'b1) begin $display("FAIL sat_set_beats_clr got %b want 1", overflow); nerr++; end
        in_pulse = 1'b0;
        step();
        ovf_clr = 1'b0;
        nvec++; if (overflow !== 1'b0) begin $display("FAIL sat_ovf_clr got %b want 0", overflow); nerr++; end
    endtask

    task automatic test_simul_incdec();
        do_reset();
        in_pulse = 1'b1; step();
        step();
        in_pulse = 1'b0;
        nvec++; if (out_pulse !== 1'b1) begin $display("FAIL incdec_issue got %b want 1", out_pulse); nerr++; end
        step();
        nvec++; if (pending !== 4'd2) begin $display("FAIL incdec_pre got %0d want 2", pending); nerr++; end
        in_pulse = 1'b1;
        step();
        in_pulse = 1'b0;
        nvec++; if (pending !== 4'd2) begin $display("FAIL incdec_net got %0d want 2", pending); nerr++; end
    endtask

    task automatic test_reset_mid();
        int n;
        int outs = 0;
        do_reset();
        mode = 1;
        for (int i = 0; i < 5; i++) begin
            in_pulse = 1'b1;
            step();
        end
        in_pulse = 1'b0;
        wait_out(20, n);
        step(); step(); step();
        nvec++; if (pending !== 4'd5) begin $display("FAIL rstmid_pre_pending got %0d want 5", pending); nerr++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode = 0;
        nvec++; if (pending !== 4'd0) begin $display("FAIL rstmid_pending got %0d want 0", pending); nerr++; end
        nvec++; if (busy !== 1'b0) begin $display("FAIL rstmid_busy got %b want 0", busy); nerr++; end
        nvec++; if (overflow !== 1'b0) begin $display("FAIL rstmid_overflow got %b want 0", overflow); nerr++; end
        nvec++; if (out_pulse !== 1'b0) begin $display("FAIL rstmid_out got %b want 0", out_pulse); nerr++; end
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_pulse) outs++;
        end
        nvec++; if (outs !== 0) begin $display("FAIL rstmid_quiet got %0d pulses want 0", outs); nerr++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_forced_reject();
        test_back_to_back();
        test_saturation();
        test_simul_incdec();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
